// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem req/ack port, 2-entry instruction queue, branch/jump redirect.
// Optional FETCH_STATS_EN adds saturating redirect/drop counters.
module fetch_unit #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i,
    input  logic        res_valid_i,
    input  logic [31:0] res_pc_i,
    input  logic [31:0] res_instr_i,
    input  logic        branch_i,
    input  logic [1:0]  branch_type_i,
    input  logic        jump_i,
    input  logic        zero_i,
    input  logic        neg_i
`ifdef FETCH_STATS_EN
    ,
    output logic [15:0] redirect_cnt_o,
    output logic [15:0] drop_cnt_o
`endif
);

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t      r_state, w_state_next;
    logic [31:0] r_pc, w_pc_next;
    logic [31:0] r_addr, w_addr_next;
    logic        r_req, w_req_next;

    logic        r_v0, r_v1, w_v0_next, w_v1_next;
    logic [31:0] r_d0, r_d1, w_d0_next, w_d1_next;
    logic [31:0] r_p0, r_p1, w_p0_next, w_p1_next;

    logic        w_branch_cond;
    logic        w_taken;
    logic [31:0] w_res_pc_plus4;
    logic [31:0] w_br_target;
    logic [31:0] w_jmp_target;
    logic [31:0] w_target;
    logic [31:0] w_pc_incr;
    logic        w_pop;
    logic        w_push;
    logic [1:0]  w_occ_after_pop;
    logic [1:0]  w_occ_next;
    logic [5:0]  w_unused_opcode;

    assign w_unused_opcode = res_instr_i[31:26];

    always_comb begin
        w_branch_cond = 1'b0;
        case (branch_type_i)
            2'd0:    w_branch_cond = zero_i;
            2'd1:    w_branch_cond = ~zero_i;
            2'd2:    w_branch_cond = zero_i | neg_i;
            default: w_branch_cond = neg_i;
        endcase
    end

    assign w_taken        = res_valid_i & (jump_i | (branch_i & w_branch_cond));
    assign w_res_pc_plus4 = res_pc_i + 32'd4;
    assign w_br_target    = w_res_pc_plus4 + {{14{res_instr_i[15]}}, res_instr_i[15:0], 2'b00};
    assign w_jmp_target   = {w_res_pc_plus4[31:28], res_instr_i[25:0], 2'b00};
    assign w_target       = jump_i ? w_jmp_target : w_br_target;
    assign w_pc_incr      = r_pc + 32'd4;

    assign w_pop           = r_v0 & instr_ready_i;
    assign w_push          = (r_state == REQ) & imem_ack_i & ~w_taken;
    assign w_occ_after_pop = {1'b0, r_v0} + {1'b0, r_v1} - {1'b0, w_pop};
    assign w_occ_next      = w_occ_after_pop + {1'b0, w_push};

    // A redirect with nothing stale in flight issues the target request on the very next cycle.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_addr_next  = r_addr;
        w_req_next   = r_req;
        case (r_state)
            IDLE: begin
                if (w_taken) begin
                    w_pc_next    = w_target;
                    w_addr_next  = w_target;
                    w_req_next   = 1'b1;
                    w_state_next = REQ;
                end else if (w_occ_after_pop < 2'd2) begin
                    w_addr_next  = r_pc;
                    w_req_next   = 1'b1;
                    w_state_next = REQ;
                end
            end
            REQ: begin
                if (imem_ack_i) begin
                    if (w_taken) begin
                        w_pc_next   = w_target;
                        w_addr_next = w_target;
                        w_req_next  = 1'b1;
                    end else begin
                        w_pc_next = w_pc_incr;
                        if (w_occ_next < 2'd2) begin
                            w_addr_next = w_pc_incr;
                            w_req_next  = 1'b1;
                        end else begin
                            w_req_next   = 1'b0;
                            w_state_next = IDLE;
                        end
                    end
                end else if (w_taken) begin
                    w_pc_next    = w_target;
                    w_state_next = DROP;
                end
            end
            DROP: begin
                if (w_taken) begin
                    w_pc_next = w_target;
                end
                if (imem_ack_i) begin
                    w_addr_next  = w_taken ? w_target : r_pc;
                    w_req_next   = 1'b1;
                    w_state_next = REQ;
                end
            end
            default: begin
                w_req_next   = 1'b0;
                w_state_next = IDLE;
            end
        endcase
    end

    // Queue is a shift register so the head always sits in entry 0.
    always_comb begin
        w_v0_next = r_v0;
        w_d0_next = r_d0;
        w_p0_next = r_p0;
        w_v1_next = r_v1;
        w_d1_next = r_d1;
        w_p1_next = r_p1;
        if (w_pop) begin
            w_v0_next = r_v1;
            w_d0_next = r_d1;
            w_p0_next = r_p1;
            w_v1_next = 1'b0;
        end
        if (w_push) begin
            if (!w_v0_next) begin
                w_v0_next = 1'b1;
                w_d0_next = imem_data_i;
                w_p0_next = r_addr;
            end else begin
                w_v1_next = 1'b1;
                w_d1_next = imem_data_i;
                w_p1_next = r_addr;
            end
        end
        if (w_taken) begin
            w_v0_next = 1'b0;
            w_v1_next = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
            r_pc    <= PC_RESET;
            r_addr  <= 32'h0;
            r_req   <= 1'b0;
            r_v0    <= 1'b0;
            r_d0    <= 32'h0;
            r_p0    <= 32'h0;
            r_v1    <= 1'b0;
            r_d1    <= 32'h0;
            r_p1    <= 32'h0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_addr  <= w_addr_next;
            r_req   <= w_req_next;
            r_v0    <= w_v0_next;
            r_d0    <= w_d0_next;
            r_p0    <= w_p0_next;
            r_v1    <= w_v1_next;
            r_d1    <= w_d1_next;
            r_p1    <= w_p1_next;
        end
    end

    assign imem_req_o    = r_req;
    assign imem_addr_o   = r_addr;
    assign instr_valid_o = r_v0;
    assign instr_o       = r_d0;
    assign instr_pc_o    = r_p0;

`ifdef FETCH_STATS_EN
    logic [15:0] r_redirect_cnt;
    logic [15:0] r_drop_cnt;
    logic        w_drop;

    // Discarded acks: the ack of a request being redirected away, or any ack of a stale request.
    assign w_drop = imem_ack_i & (((r_state == REQ) & w_taken) | (r_state == DROP));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_redirect_cnt <= 16'h0;
            r_drop_cnt     <= 16'h0;
        end else begin
            if (w_taken && (r_redirect_cnt != 16'hFFFF)) begin
                r_redirect_cnt <= r_redirect_cnt + 16'd1;
            end
            if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    assign redirect_cnt_o = r_redirect_cnt;
    assign drop_cnt_o     = r_drop_cnt;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: scoreboard of fetched (pc, word) pairs plus directed redirect checks.
module tb_fetch_unit;

    logic        clk_i;
    logic        rst_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_data_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i;
    logic        res_valid_i;
    logic [31:0] res_pc_i;
    logic [31:0] res_instr_i;
    logic        branch_i;
    logic [1:0]  branch_type_i;
    logic        jump_i;
    logic        zero_i;
    logic        neg_i;
`ifdef FETCH_STATS_EN
    logic [15:0] redirect_cnt_o;
    logic [15:0] drop_cnt_o;
`endif

    int          assertCount = 0;
    int          failCount = 0;
    int          ackSeen = 0;
    logic [63:0] sbq[$];
    logic        sbOn = 1'b0;
    logic        ackEn = 1'b0;
    logic [31:0] expPc = 32'h0;

    fetch_unit #(.PC_RESET(32'h0000_0000)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_data_i   (imem_data_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_ready_i (instr_ready_i),
        .res_valid_i   (res_valid_i),
        .res_pc_i      (res_pc_i),
        .res_instr_i   (res_instr_i),
        .branch_i      (branch_i),
        .branch_type_i (branch_type_i),
        .jump_i        (jump_i),
        .zero_i        (zero_i),
        .neg_i         (neg_i)
`ifdef FETCH_STATS_EN
        ,
        .redirect_cnt_o(redirect_cnt_o),
        .drop_cnt_o    (drop_cnt_o)
`endif
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1357_9BDF;
    endfunction

    // One clock: memory answers at the falling edge, scoreboard pops consumed heads and pushes accepted fetches.
    task automatic tick();
        logic [63:0] exp;
        @(negedge clk_i);
        imem_ack_i  = ackEn && imem_req_o;
        imem_data_i = memWord(imem_addr_o);
        if (imem_ack_i) ackSeen++;
        if (sbOn) begin
            if (instr_valid_o && instr_ready_i) begin
                assertCount++;
                if (sbq.size() == 0) begin
                    failCount++;
                    $display("[TB] FAIL sb_underflow: head pc %h delivered with nothing expected", instr_pc_o);
                end else begin
                    exp = sbq.pop_front();
                    if ({instr_pc_o, instr_o} !== exp) begin
                        failCount++;
                        $display("[TB] FAIL sb_head: got pc/instr %h expected %h", {instr_pc_o, instr_o}, exp);
                    end
                end
            end
            if (imem_ack_i) begin
                assertCount++;
                if (imem_addr_o !== expPc) begin
                    failCount++;
                    $display("[TB] FAIL sb_fetch_addr: got %h expected %h", imem_addr_o, expPc);
                end
                sbq.push_back({expPc, memWord(expPc)});
                expPc = expPc + 32'd4;
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic applyStimulus(input logic b, input logic [1:0] bt, input logic j, input logic z,
                                 input logic n, input logic [31:0] rpc, input logic [31:0] rinstr);
        res_valid_i   = 1'b1;
        branch_i      = b;
        branch_type_i = bt;
        jump_i        = j;
        zero_i        = z;
        neg_i         = n;
        res_pc_i      = rpc;
        res_instr_i   = rinstr;
        tick();
        res_valid_i = 1'b0;
        branch_i    = 1'b0;
        jump_i      = 1'b0;
    endtask

    task automatic doReset(input logic readyVal);
        @(negedge clk_i);
        rst_i         = 1'b0;
        imem_ack_i    = 1'b0;
        res_valid_i   = 1'b0;
        instr_ready_i = readyVal;
        sbOn          = 1'b0;
        @(negedge clk_i);
        sbq.delete();
        expPc   = 32'h0;
        ackSeen = 0;
        rst_i   = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] expv);
        assertCount++;
        if (got !== expv) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, expv);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        #1;
        checkOutput("reset_req", {31'b0, imem_req_o}, 32'h0);
        checkOutput("reset_addr", imem_addr_o, 32'h0);
        checkOutput("reset_valid", {31'b0, instr_valid_o}, 32'h0);
        checkOutput("reset_instr", instr_o, 32'h0);
        checkOutput("reset_pc", instr_pc_o, 32'h0);
`ifdef FETCH_STATS_EN
        checkOutput("reset_drop_cnt", {16'b0, drop_cnt_o}, 32'h0);
`endif
    endtask

    task automatic test_sequential();
        doReset(1'b1);
        ackEn = 1'b1;
        sbOn  = 1'b1;
        checkOutput("first_req", {31'b0, imem_req_o}, 32'h1);
        checkOutput("first_addr", imem_addr_o, 32'h0);
        checkOutput("first_valid", {31'b0, instr_valid_o}, 32'h0);
        for (int k = 0; k < 4; k++) begin
            tick();
            checkOutput("seq_valid", {31'b0, instr_valid_o}, 32'h1);
            checkOutput("seq_pc", instr_pc_o, 32'(k * 4));
        end
    endtask

    task automatic test_back_pressure();
        doReset(1'b0);
        ackEn = 1'b1;
        sbOn  = 1'b1;
        repeat (6) tick();
        checkOutput("bp_ack_count", 32'(ackSeen), 32'd2);
        checkOutput("bp_req_low", {31'b0, imem_req_o}, 32'h0);
        checkOutput("bp_head_pc", instr_pc_o, 32'h0);
        instr_ready_i = 1'b1;
        tick();
        checkOutput("bp_resume_req", {31'b0, imem_req_o}, 32'h1);
        checkOutput("bp_resume_addr", imem_addr_o, 32'h8);
        repeat (4) tick();
    endtask

    task automatic test_branch();
        doReset(1'b1);
        ackEn = 1'b1;
        sbOn  = 1'b1;
        repeat (3) tick();
        sbOn = 1'b0;
        applyStimulus(1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0000_FFFF);
        checkOutput("beq_flush_valid", {31'b0, instr_valid_o}, 32'h0);
        checkOutput("beq_req", {31'b0, imem_req_o}, 32'h1);
        checkOutput("beq_target", imem_addr_o, 32'h10);
        sbq.delete();
        expPc = 32'h10;
        sbOn  = 1'b1;
        repeat (3) tick();
        checkOutput("beq_after_pc", instr_pc_o, 32'h18);
        applyStimulus(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0000_FFFF);
        repeat (3) tick();
        checkOutput("beq_nt_valid", {31'b0, instr_valid_o}, 32'h1);
        checkOutput("beq_nt_pc", instr_pc_o, 32'h28);
    endtask

    task automatic test_jump();
        doReset(1'b1);
        ackEn = 1'b1;
        repeat (3) tick();
        applyStimulus(1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 32'h1000_0040, {6'b000010, 26'h000_0100});
        checkOutput("jump_flush_valid", {31'b0, instr_valid_o}, 32'h0);
        checkOutput("jump_target", imem_addr_o, 32'h1000_0400);
        applyStimulus(1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 32'h200, 32'h0000_0003);
        checkOutput("ble_req", {31'b0, imem_req_o}, 32'h1);
        checkOutput("ble_target", imem_addr_o, 32'h210);
        sbq.delete();
        expPc = 32'h210;
        sbOn  = 1'b1;
        applyStimulus(1'b1, 2'd3, 1'b0, 1'b1, 1'b0, 32'h300, 32'h0000_0040);
        repeat (3) tick();
        checkOutput("bltz_nt_pc", instr_pc_o, 32'h21C);
    endtask

    task automatic test_drop();
        doReset(1'b0);
        ackEn = 1'b1;
        repeat (6) tick();
        checkOutput("drop_setup_idle", {31'b0, imem_req_o}, 32'h0);
        ackEn = 1'b0;
        applyStimulus(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 32'h0, {6'b000010, 26'h000_0008});
        checkOutput("drop_req_20", imem_addr_o, 32'h20);
        checkOutput("drop_req_valid", {31'b0, instr_valid_o}, 32'h0);
        applyStimulus(1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 32'h100, 32'h0000_0004);
        for (int k = 0; k < 3; k++) begin
            checkOutput("drop_hold_req", {31'b0, imem_req_o}, 32'h1);
            checkOutput("drop_hold_addr", imem_addr_o, 32'h20);
            tick();
        end
        ackEn = 1'b1;
        tick();
        ackEn = 1'b0;
        checkOutput("drop_new_req", {31'b0, imem_req_o}, 32'h1);
        checkOutput("drop_new_addr", imem_addr_o, 32'h114);
        checkOutput("drop_no_data", {31'b0, instr_valid_o}, 32'h0);
`ifdef FETCH_STATS_EN
        checkOutput("drop_cnt", {16'b0, drop_cnt_o}, 32'd1);
        checkOutput("redirect_cnt", {16'b0, redirect_cnt_o}, 32'd2);
`endif
    endtask

    task automatic test_async_reset();
        doReset(1'b1);
        ackEn = 1'b1;
        repeat (3) tick();
        #2;
        rst_i = 1'b0;
        #1;
        checkOutput("areset_req", {31'b0, imem_req_o}, 32'h0);
        checkOutput("areset_addr", imem_addr_o, 32'h0);
        checkOutput("areset_valid", {31'b0, instr_valid_o}, 32'h0);
        checkOutput("areset_instr", instr_o, 32'h0);
        checkOutput("areset_pc", instr_pc_o, 32'h0);
        @(negedge clk_i);
        imem_ack_i = 1'b0;
        rst_i      = 1'b1;
        @(posedge clk_i);
        #1;
        checkOutput("areset_restart_req", {31'b0, imem_req_o}, 32'h1);
        checkOutput("areset_restart_addr", imem_addr_o, 32'h0);
    endtask

    initial begin
        rst_i         = 1'b1;
        imem_ack_i    = 1'b0;
        imem_data_i   = 32'h0;
        instr_ready_i = 1'b0;
        res_valid_i   = 1'b0;
        res_pc_i      = 32'h0;
        res_instr_i   = 32'h0;
        branch_i      = 1'b0;
        branch_type_i = 2'd0;
        jump_i        = 1'b0;
        zero_i        = 1'b0;
        neg_i         = 1'b0;
        #2;
        test_reset();
        test_sequential();
        test_back_pressure();
        test_branch();
        test_jump();
        test_drop();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
